// File: rtl/gcd_host_sequencer.sv
// Host-side sequencer for the GCD core: accepts an operand pair, loads it onto the
// core's shared data bus, waits for done (or a timeout) and returns the result.
module gcd_host_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_next;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // A zero operand never reaches the core: gcd(0,x)=x is answered directly.
  always_comb begin
    state_next = state;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          a_d = in_a;
          b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            result_d   = in_a | in_b;
            err_d      = 1'b0;
            state_next = RESP;
          end else begin
            state_next = LOAD_A;
          end
        end
      end
      LOAD_A: state_next = LOAD_B;
      LOAD_B: begin
        cnt_d      = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (gcd_done) begin
          result_d   = gcd_result;
          err_d      = 1'b0;
          state_next = RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d   = '0;
          err_d      = 1'b1;
          state_next = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gcd_data = '0;
    unique case (state)
      LOAD_A:       gcd_data = a_q;
      LOAD_B, WAIT: gcd_data = b_q;
      default:      gcd_data = '0;
    endcase
  end

  assign in_ready   = (state == IDLE) && !rst;
  assign gcd_start  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid  = (state == RESP);
  assign out_result = result_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_gcd_host_sequencer.sv
// Directed bench for gcd_host_sequencer with a behavioural GCD core and a
// response scoreboard; TIMEOUT is shrunk to 8 so the hung-core path is reachable.
module tb_gcd_host_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_err;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   start_cnt = 0;
  int   resp_cnt = 0;

  int         core_lat = 3;
  bit         core_never = 1'b0;
  logic [1:0] m_phase = 2'd0;
  logic [WIDTH-1:0] m_a = '0, m_res = '0;
  int         m_cnt = 0;

  always #5 clk = ~clk;

  gcd_host_sequencer #(.WIDTH(WIDTH), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  function automatic logic [WIDTH-1:0] gcd_fn(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] a, b, t;
    a = x;
    b = y;
    while (b != '0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Core model: first start cycle loads A, second loads B, done after core_lat WAIT cycles.
  always @(posedge clk) begin
    if (gcd_start) begin
      if (m_phase == 2'd1) begin
        m_res   <= gcd_fn(m_a, gcd_data);
        m_phase <= 2'd2;
        m_cnt   <= 0;
      end else begin
        m_a     <= gcd_data;
        m_phase <= 2'd1;
      end
    end else if (m_phase == 2'd2) begin
      if (gcd_done) m_phase <= 2'd0;
      else          m_cnt   <= m_cnt + 1;
    end
  end

  assign gcd_done   = (m_phase == 2'd2) && !core_never && (m_cnt == core_lat);
  assign gcd_result = m_res;

  always @(posedge clk) begin
    if (gcd_start) start_cnt <= start_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] exp_res, input logic exp_err,
                                input bit hold_valid);
    int n = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    step();
    if (!hold_valid) in_valid = 1'b0;
    exp_q.push_back('{err: exp_err, res: exp_res});
  endtask

  task automatic check_output(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 300) begin
      step();
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 32'(out_result), 32'(e.res));
      check({tag, "_err"}, 32'(out_err), 32'(e.err));
    end
    resp_cnt++;
    step();
  endtask

  initial begin
    int lat;
    int s0;
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    out_ready  = 1'b1;
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_gcd_start", 32'(gcd_start), 32'd0);
    check("rst_gcd_data", 32'(gcd_data), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    step();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] test 1: normal transaction 143,78");
    s0 = start_cnt;
    apply_stimulus(16'd143, 16'd78, 16'd13, 1'b0, 1'b0);
    check("t1_loada_start", 32'(gcd_start), 32'd1);
    check("t1_loada_data", 32'(gcd_data), 32'd143);
    step();
    check("t1_loadb_start", 32'(gcd_start), 32'd1);
    check("t1_loadb_data", 32'(gcd_data), 32'd78);
    step();
    check("t1_wait_start", 32'(gcd_start), 32'd0);
    check("t1_wait_data", 32'(gcd_data), 32'd78);
    check_output("t1", lat);
    check("t1_start_cycles", 32'(start_cnt - s0), 32'd2);

    $display("[TB] test 2: zero operands");
    s0 = start_cnt;
    apply_stimulus(16'd0, 16'd25, 16'd25, 1'b0, 1'b0);
    check_output("t2a", lat);
    check("t2a_latency", 32'(lat), 32'd0);
    apply_stimulus(16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check_output("t2b", lat);
    check("t2b_latency", 32'(lat), 32'd0);
    check("t2_no_start", 32'(start_cnt - s0), 32'd0);

    $display("[TB] test 3: backpressure 48,18");
    out_ready = 1'b0;
    apply_stimulus(16'd48, 16'd18, 16'd6, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
    check("t3_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_result", 32'(out_result), 32'd6);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    check_output("t3", lat);
    check("t3_in_ready_after", 32'(in_ready), 32'd1);
    check("t3_valid_after", 32'(out_valid), 32'd0);

    $display("[TB] test 4: timeout and late done");
    core_never = 1'b1;
    apply_stimulus(16'd5, 16'd3, 16'd0, 1'b1, 1'b0);
    check_output("t4a", lat);
    check("t4a_wait_cycles", 32'(lat - 2), 32'd8);
    core_never = 1'b0;
    core_lat   = 7;
    apply_stimulus(16'd48, 16'd36, 16'd12, 1'b0, 1'b0);
    check_output("t4b", lat);
    check("t4b_wait_cycles", 32'(lat - 2), 32'd8);

    $display("[TB] test 5: reset during WAIT");
    core_lat = 5;
    apply_stimulus(16'd1071, 16'd462, 16'd21, 1'b0, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    step();
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_gcd_start", 32'(gcd_start), 32'd0);
    check("t5_gcd_data", 32'(gcd_data), 32'd0);
    check("t5_out_result", 32'(out_result), 32'd0);
    check("t5_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    step();
    apply_stimulus(16'd1071, 16'd462, 16'd21, 1'b0, 1'b0);
    check_output("t5", lat);

    $display("[TB] test 6: back-to-back requests");
    core_lat = 3;
    resp_cnt = 0;
    apply_stimulus(16'd143, 16'd78, 16'd13, 1'b0, 1'b1);
    check("t6_busy1", 32'(in_ready), 32'd0);
    check_output("t6a", lat);
    apply_stimulus(16'd17, 16'd5, 16'd1, 1'b0, 1'b1);
    check("t6_busy2", 32'(in_ready), 32'd0);
    check_output("t6b", lat);
    apply_stimulus(16'd100, 16'd75, 16'd25, 1'b0, 1'b0);
    check("t6_busy3", 32'(in_ready), 32'd0);
    check_output("t6c", lat);
    repeat (12) begin
      step();
      check("t6_no_extra_valid", 32'(out_valid), 32'd0);
    end
    check("t6_resp_count", 32'(resp_cnt), 32'd3);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
